// File: rtl/stage_sequencer.sv
// Game-flow controller: steps through NUM_STAGES stages with a lives counter and
// stage retry, driving the datapath with a one-hot phase vector and a stage index.
//
// state      | meaning
// WAIT_START | idle, waiting for a start key edge
// START_DISP | start screen being drawn
// BEGIN      | stage-begin drawing
// TOWER      | tower placement
// PROGRESS   | cars running, waiting for clear or loss
// END_DISP   | stage-end screen
// LOSE_DISP  | life-lost screen, then retry same stage
// WIN        | terminal win, start edge begins a new game
// GAME_OVER  | terminal loss, start edge begins a new game
module stage_sequencer #(
  parameter int NUM_STAGES = 3,
  parameter int STAGE_W    = 2,
  parameter int MAX_LIVES  = 3,
  parameter int LIFE_W     = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               start_display_done,
  input  logic               begin_done,
  input  logic               tower_done,
  input  logic               car_done,
  input  logic               end_display_done,
  input  logic               game_over_in,
  input  logic               lose_display_done,
  output logic               wait_start,
  output logic               start_display,
  output logic [3:0]         phase,
  output logic [STAGE_W-1:0] stage,
  output logic [LIFE_W-1:0]  lives,
  output logic               lose_display,
  output logic               win,
  output logic               game_over,
  output logic               phase_entry
);

  typedef enum logic [3:0] {
    WAIT_START = 4'd0,
    START_DISP = 4'd1,
    BEGIN      = 4'd2,
    TOWER      = 4'd3,
    PROGRESS   = 4'd4,
    END_DISP   = 4'd5,
    LOSE_DISP  = 4'd6,
    WIN        = 4'd7,
    GAME_OVER  = 4'd8
  } state_t;

  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
  localparam logic [LIFE_W-1:0]  LIVES_INIT = LIFE_W'(MAX_LIVES);
  localparam logic [LIFE_W-1:0]  ONE_LIFE   = LIFE_W'(1);
  localparam logic [STAGE_W-1:0] ONE_STAGE  = STAGE_W'(1);

  state_t               state_q, state_d;
  logic                 start_q;
  logic [STAGE_W-1:0]   stage_q, stage_d;
  logic [LIFE_W-1:0]    lives_q, lives_d;
  logic                 phase_entry_q;
  logic                 start_edge;

  assign start_edge = start & ~start_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= WAIT_START;
      start_q       <= 1'b0;
      stage_q       <= '0;
      lives_q       <= LIVES_INIT;
      phase_entry_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_q       <= start;
      stage_q       <= stage_d;
      lives_q       <= lives_d;
      phase_entry_q <= (state_d != state_q);
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    lives_d = lives_q;
    case (state_q)
      WAIT_START: if (start_edge) state_d = START_DISP;
      START_DISP: begin
        if (start_display_done) begin
          state_d = BEGIN;
          stage_d = '0;
          lives_d = LIVES_INIT;
        end
      end
      BEGIN:      if (begin_done) state_d = TOWER;
      TOWER:      if (tower_done) state_d = PROGRESS;
      PROGRESS: begin
        // A loss outranks a simultaneous stage clear.
        if (game_over_in) begin
          if (lives_q > ONE_LIFE) begin
            lives_d = lives_q - ONE_LIFE;
            state_d = LOSE_DISP;
          end else begin
            lives_d = '0;
            state_d = GAME_OVER;
          end
        end else if (car_done) begin
          state_d = END_DISP;
        end
      end
      END_DISP: begin
        if (end_display_done) begin
          if (stage_q == LAST_STAGE) begin
            state_d = WIN;
          end else begin
            stage_d = stage_q + ONE_STAGE;
            state_d = BEGIN;
          end
        end
      end
      LOSE_DISP:  if (lose_display_done) state_d = BEGIN;
      WIN:        if (start_edge) state_d = START_DISP;
      GAME_OVER:  if (start_edge) state_d = START_DISP;
      default:    state_d = WAIT_START;
    endcase
  end

  assign wait_start    = (state_q == WAIT_START);
  assign start_display = (state_q == START_DISP);
  assign phase         = {state_q == END_DISP, state_q == PROGRESS,
                          state_q == TOWER, state_q == BEGIN};
  assign lose_display  = (state_q == LOSE_DISP);
  assign win           = (state_q == WIN);
  assign game_over     = (state_q == GAME_OVER);
  assign stage         = stage_q;
  assign lives         = lives_q;
  assign phase_entry   = phase_entry_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: walks a clean win, a game with retries and
// a final loss, done-strobe isolation and a mid-game reset.
module tb_stage_sequencer;

  logic       clk = 1'b0;
  logic       resetn, start;
  logic       start_display_done, begin_done, tower_done, car_done;
  logic       end_display_done, game_over_in, lose_display_done;
  logic       wait_start, start_display, lose_display, win, game_over, phase_entry;
  logic [3:0] phase;
  logic [1:0] stage, lives;

  int checks = 0;
  int failures = 0;

  localparam logic [6:0] SD = 7'h01, BD = 7'h02, TD = 7'h04, CD = 7'h08,
                         ED = 7'h10, GO = 7'h20, LD = 7'h40, NONE = 7'h00;
  localparam logic [8:0] O_WAIT = 9'h001, O_SDISP = 9'h002, O_BEGIN = 9'h004,
                         O_TOWER = 9'h008, O_PROG = 9'h010, O_END = 9'h020,
                         O_LOSE = 9'h040, O_WIN = 9'h080, O_GOVER = 9'h100;

  stage_sequencer #(.NUM_STAGES(3), .STAGE_W(2), .MAX_LIVES(3), .LIFE_W(2)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .start_display_done(start_display_done), .begin_done(begin_done),
    .tower_done(tower_done), .car_done(car_done),
    .end_display_done(end_display_done), .game_over_in(game_over_in),
    .lose_display_done(lose_display_done),
    .wait_start(wait_start), .start_display(start_display), .phase(phase),
    .stage(stage), .lives(lives), .lose_display(lose_display), .win(win),
    .game_over(game_over), .phase_entry(phase_entry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [8:0] eo, input int es,
                           input int el, input logic ep);
    chk({tag, ".outs"}, {game_over, win, lose_display, phase, start_display, wait_start}, eo);
    chk({tag, ".stage"}, stage, es);
    chk({tag, ".lives"}, lives, el);
    chk({tag, ".entry"}, phase_entry, ep);
  endtask

  task automatic step(input string tag, input logic [6:0] d, input logic [8:0] eo,
                      input int es, input int el, input logic ep);
    {lose_display_done, game_over_in, end_display_done, car_done,
     tower_done, begin_done, start_display_done} = d;
    tick();
    {lose_display_done, game_over_in, end_display_done, car_done,
     tower_done, begin_done, start_display_done} = NONE;
    check_all(tag, eo, es, el, ep);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0;
    {lose_display_done, game_over_in, end_display_done, car_done,
     tower_done, begin_done, start_display_done} = NONE;
    tick(); tick();
    check_all("reset", O_WAIT, 0, 3, 1'b0);
    resetn = 1'b1;
    step("idle", NONE, O_WAIT, 0, 3, 1'b0);
    step("idle_dones_ignored", SD | BD | GO, O_WAIT, 0, 3, 1'b0);

    // Start edge, then hold start: single trigger only.
    start = 1'b1;
    step("start_edge", NONE, O_SDISP, 0, 3, 1'b1);
    for (int i = 0; i < 10; i++) step("start_held", NONE, O_SDISP, 0, 3, 1'b0);
    start = 1'b0;
    step("start_disp_wait", NONE, O_SDISP, 0, 3, 1'b0);
    step("sd_done", SD, O_BEGIN, 0, 3, 1'b1);

    // tower_done held in BEGIN must not advance.
    step("begin_tower_held", TD, O_BEGIN, 0, 3, 1'b0);
    step("begin_done_w_td", BD | TD, O_TOWER, 0, 3, 1'b1);
    step("tower_done_held", TD, O_PROG, 0, 3, 1'b1);
    step("prog_wait", NONE, O_PROG, 0, 3, 1'b0);
    step("car0", CD, O_END, 0, 3, 1'b1);
    step("end0_held_car", CD, O_END, 0, 3, 1'b0);
    step("end0", ED, O_BEGIN, 1, 3, 1'b1);

    for (int s = 1; s < 3; s++) begin
      step("win_bd", BD, O_TOWER, s, 3, 1'b1);
      step("win_td", TD, O_PROG, s, 3, 1'b1);
      step("win_cd", CD, O_END, s, 3, 1'b1);
      if (s < 2) step("win_ed", ED, O_BEGIN, s + 1, 3, 1'b1);
      else       step("win_ed_last", ED, O_WIN, 2, 3, 1'b1);
    end
    step("win_hold", ED | SD, O_WIN, 2, 3, 1'b0);

    // New game from WIN.
    start = 1'b1;
    step("restart_from_win", NONE, O_SDISP, 2, 3, 1'b1);
    start = 1'b0;
    step("g2_sd", SD, O_BEGIN, 0, 3, 1'b1);

    // Stage 0: plain loss and retry.
    step("g2_bd0", BD, O_TOWER, 0, 3, 1'b1);
    step("g2_td0", TD, O_PROG, 0, 3, 1'b1);
    step("g2_loss1", GO, O_LOSE, 0, 2, 1'b1);
    step("g2_lose_wait", BD, O_LOSE, 0, 2, 1'b0);
    step("g2_retry0", LD, O_BEGIN, 0, 2, 1'b1);
    step("g2_bd0b", BD, O_TOWER, 0, 2, 1'b1);
    step("g2_td0b", TD, O_PROG, 0, 2, 1'b1);
    step("g2_cd0", CD, O_END, 0, 2, 1'b1);
    step("g2_ed0", ED, O_BEGIN, 1, 2, 1'b1);

    // Stage 1: loss and clear together, loss wins.
    step("g2_bd1", BD, O_TOWER, 1, 2, 1'b1);
    step("g2_td1", TD, O_PROG, 1, 2, 1'b1);
    step("g2_loss2_prio", GO | CD, O_LOSE, 1, 1, 1'b1);
    step("g2_retry1", LD, O_BEGIN, 1, 1, 1'b1);
    step("g2_bd1b", BD, O_TOWER, 1, 1, 1'b1);
    step("g2_td1b", TD, O_PROG, 1, 1, 1'b1);
    step("g2_loss3_final", GO, O_GOVER, 1, 0, 1'b1);
    step("gover_hold", GO | LD | SD, O_GOVER, 1, 0, 1'b0);

    // New game from GAME_OVER restores lives and stage.
    start = 1'b1;
    step("restart_from_gover", NONE, O_SDISP, 1, 0, 1'b1);
    start = 1'b0;
    step("g3_sd", SD, O_BEGIN, 0, 3, 1'b1);
    for (int s = 0; s < 2; s++) begin
      step("g3_bd", BD, O_TOWER, s, 3, 1'b1);
      step("g3_td", TD, O_PROG, s, 3, 1'b1);
      step("g3_cd", CD, O_END, s, 3, 1'b1);
      step("g3_ed", ED, O_BEGIN, s + 1, 3, 1'b1);
    end
    step("g3_bd2", BD, O_TOWER, 2, 3, 1'b1);
    step("g3_td2", TD, O_PROG, 2, 3, 1'b1);

    // Reset mid-game overrides a concurrent car_done.
    resetn = 1'b0;
    step("midgame_reset", CD, O_WAIT, 0, 3, 1'b0);
    resetn = 1'b1;
    step("post_reset_idle", NONE, O_WAIT, 0, 3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
